// File: rtl/h264_bitstream_drain.sv
// Drains the packer's 32-bit bitstream buffer into memory as sequential word writes on a
// valid/ready port, then pulses h264_buf_clear so the packer restarts at word 0.
module h264_bitstream_drain #(
    parameter int unsigned BUF_DEPTH  = 256,
    parameter int unsigned FLUSH_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h264_reset,
    input  logic        drain_en,
    input  logic [31:0] base_addr,
    input  logic        h264_enc_last4x4,
    input  logic [31:0] h264_buf_cnt,
    input  logic [31:0] h264_out,
    output logic [7:0]  h264_addr,
    output logic        h264_buf_clear,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_ready,
    output logic        frame_done,
    output logic [31:0] frame_words
);

    localparam int unsigned IW = $clog2(BUF_DEPTH + 1);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StWaitFlush = 3'd1;
    localparam logic [2:0] StRd        = 3'd2;
    localparam logic [2:0] StLatch     = 3'd3;
    localparam logic [2:0] StWr        = 3'd4;
    localparam logic [2:0] StClear     = 3'd5;
    localparam logic [2:0] StDone      = 3'd6;

    logic [2:0]    state_q;
    logic          pend_last_q;
    logic          last_q;
    logic          new_frame_q;
    logic          wr_req_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] n_q;
    logic [IW-1:0] cnt_clamped;
    logic [31:0]   wait_q;
    logic [31:0]   frame_words_q;
    logic [31:0]   base_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   wr_data_q;

    always_comb begin
        cnt_clamped = IW'(BUF_DEPTH);
        if (h264_buf_cnt < 32'(BUF_DEPTH)) begin
            cnt_clamped = IW'(h264_buf_cnt);
        end
    end

    assign h264_addr      = 8'(idx_q);
    assign h264_buf_clear = (state_q == StClear);
    assign frame_done     = (state_q == StDone);
    assign wr_req         = wr_req_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign frame_words    = frame_words_q;

    always_ff @(posedge clk) begin
        if (rst || h264_reset) begin
            state_q       <= StIdle;
            pend_last_q   <= 1'b0;
            last_q        <= 1'b0;
            new_frame_q   <= 1'b1;
            wr_req_q      <= 1'b0;
            idx_q         <= '0;
            n_q           <= '0;
            wait_q        <= '0;
            frame_words_q <= '0;
            base_q        <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            if (h264_enc_last4x4) begin
                pend_last_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (drain_en && (pend_last_q || h264_buf_cnt >= 32'(BUF_DEPTH))) begin
                        // First drain of a frame fixes its base and restarts the word count
                        if (new_frame_q) begin
                            frame_words_q <= '0;
                            base_q        <= base_addr;
                            new_frame_q   <= 1'b0;
                        end
                        if (pend_last_q) begin
                            pend_last_q <= h264_enc_last4x4;
                            wait_q      <= '0;
                            state_q     <= StWaitFlush;
                        end else begin
                            n_q     <= IW'(BUF_DEPTH);
                            last_q  <= 1'b0;
                            state_q <= StRd;
                        end
                    end
                end
                StWaitFlush: begin
                    if (wait_q + 32'd1 >= 32'(FLUSH_WAIT)) begin
                        n_q     <= cnt_clamped;
                        last_q  <= 1'b1;
                        state_q <= (cnt_clamped == '0) ? StDone : StRd;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                StRd: begin
                    state_q <= StLatch;
                end
                StLatch: begin
                    wr_data_q <= h264_out;
                    wr_addr_q <= base_q + {frame_words_q[29:0], 2'b00};
                    wr_req_q  <= 1'b1;
                    state_q   <= StWr;
                end
                StWr: begin
                    if (wr_ready) begin
                        wr_req_q      <= 1'b0;
                        idx_q         <= idx_q + IW'(1);
                        frame_words_q <= frame_words_q + 32'd1;
                        state_q       <= ((idx_q + IW'(1)) == n_q) ? StClear : StRd;
                    end
                end
                StClear: begin
                    idx_q   <= '0;
                    state_q <= last_q ? StDone : StIdle;
                end
                StDone: begin
                    new_frame_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h264_bitstream_drain.sv
// Randomized bench for h264_bitstream_drain: a packer-buffer model, a memory responder
// with selectable backpressure, and a queue of expected writes built from frame rules.
module tb_h264_bitstream_drain;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned FW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        h264_reset;
    logic        drain_en;
    logic [31:0] base_addr;
    logic        last4x4;
    logic [31:0] buf_cnt;
    logic [31:0] h264_out = '0;
    logic [7:0]  h264_addr;
    logic        clr;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready = 1'b0;
    logic        frame_done;
    logic [31:0] frame_words;

    always #5 clk = ~clk;

    h264_bitstream_drain #(
        .BUF_DEPTH  (DEPTH),
        .FLUSH_WAIT (FW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .h264_reset       (h264_reset),
        .drain_en         (drain_en),
        .base_addr        (base_addr),
        .h264_enc_last4x4 (last4x4),
        .h264_buf_cnt     (buf_cnt),
        .h264_out         (h264_out),
        .h264_addr        (h264_addr),
        .h264_buf_clear   (clr),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .frame_done       (frame_done),
        .frame_words      (frame_words)
    );

    logic [31:0] buf_mem [DEPTH];
    always @(posedge clk) h264_out <= buf_mem[h264_addr];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: 1 = always ready, 2 = 0,0,1 per word, 3 = stop after stop_after
    // accepted writes, other = random.
    int ready_mode = 1;
    int stop_after = 0;
    int stall_ctr  = 0;
    int acc_cnt    = 0;
    int clr_cnt    = 0;
    int done_cnt   = 0;
    int clr_cyc    = 0;
    int done_cyc   = 0;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: wr_ready = 1'b1;
            2: begin
                if (wr_req) begin
                    wr_ready  = (stall_ctr == 2);
                    stall_ctr = (stall_ctr == 2) ? 0 : stall_ctr + 1;
                end else begin
                    wr_ready  = 1'b0;
                    stall_ctr = 0;
                end
            end
            3: wr_ready = (acc_cnt < stop_after);
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_req", 32'(wr_req), 32'd1);
                check("stall_addr", wr_addr, prev_addr);
                check("stall_data", wr_data, prev_data);
            end
            if (wr_req && wr_ready) begin
                acc_cnt++;
                check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_addr", wr_addr, w.addr);
                    check("wr_data", wr_data, w.data);
                end
            end
            if (clr) begin
                clr_cnt++;
                clr_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("clr_done_overlap", 32'(clr), 32'd0);
            end
        end
        prev_stall = wr_req && !wr_ready && !rst;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
    end

    logic [31:0] base_m;
    int          fw_m;

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_t w;
            buf_mem[i] = $urandom;
            w.addr = base_m + (32'(fw_m + i) << 2);
            w.data = buf_mem[i];
            exp_q.push_back(w);
        end
        fw_m += n;
    endtask

    task automatic wait_done(input int done0, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            tick(1);
            if (done_cnt != done0) ok = 1'b1;
        end
        check("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_zero_outputs();
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_clear", 32'(clr), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_rd_addr", 32'(h264_addr), 32'd0);
        check("rst_frame_words", frame_words, 32'd0);
    endtask

    // One frame-end drain of n words as a fresh frame.
    task automatic run_frame(input int n, input logic [31:0] base, input int mode,
                             input int en_delay);
        int p;
        int acc0 = acc_cnt;
        int clr0 = clr_cnt;
        int done0 = done_cnt;
        ready_mode = mode;
        base_addr  = base;
        base_m     = base;
        fw_m       = 0;
        push_words(n);
        buf_cnt = 32'(n);
        if (en_delay > 0) drain_en = 1'b0;
        last4x4 = 1'b1;
        p = cyc;
        tick(1);
        last4x4 = 1'b0;
        if (en_delay > 0) begin
            tick(en_delay);
            check("dis_no_wr", 32'(acc_cnt - acc0), 32'd0);
            check("dis_no_done", 32'(done_cnt - done0), 32'd0);
            drain_en = 1'b1;
        end
        wait_done(done0, 200 + 12 * n);
        buf_cnt = '0;
        check("frame_words", frame_words, 32'(fw_m));
        check("wr_left", 32'(exp_q.size()), 32'd0);
        check("wr_count", 32'(acc_cnt - acc0), 32'(n));
        check("clear_count", 32'(clr_cnt - clr0), (n > 0) ? 32'd1 : 32'd0);
        if (mode == 1 && en_delay == 0)
            check("frame_latency", 32'(done_cyc - (p + 1)),
                  (n > 0) ? 32'(FW + 3 * n + 2) : 32'(FW + 1));
        if (n > 0) check("clr_to_done", 32'(done_cyc - clr_cyc), 32'd1);
        exp_q.delete();
        tick(2);
    endtask

    // Full-buffer drain with an end-of-frame pulse arriving mid-drain.
    task automatic full_then_frame();
        int c0;
        bit seen = 1'b0;
        int acc0 = acc_cnt;
        int clr0 = clr_cnt;
        int done0 = done_cnt;
        ready_mode = 1;
        base_addr  = 32'hFFFF_FF00;
        base_m     = base_addr;
        fw_m       = 0;
        push_words(DEPTH);
        buf_cnt = 32'(DEPTH);
        c0 = cyc;
        for (int k = 0; k < 1000 && !seen; k++) begin
            tick(1);
            last4x4 = (cyc == c0 + 100);
            if (clr) begin
                seen = 1'b1;
                check("full_clr_time", 32'(cyc - c0), 32'(3 * DEPTH + 1));
                check("full_no_done", 32'(done_cnt - done0), 32'd0);
                check("full_wr_count", 32'(acc_cnt - acc0), 32'(DEPTH));
                push_words(5);
                buf_cnt = 32'd5;
            end
        end
        last4x4 = 1'b0;
        check("full_clr_seen", 32'(seen), 32'd1);
        wait_done(done0, 400);
        buf_cnt = '0;
        check("full_frame_words", frame_words, 32'd261);
        check("full_wr_left", 32'(exp_q.size()), 32'd0);
        check("full_clear_count", 32'(clr_cnt - clr0), 32'd2);
        exp_q.delete();
        tick(2);
    endtask

    task automatic reset_mid_drain();
        bit found = 1'b0;
        int acc0 = acc_cnt;
        stop_after = acc_cnt + 1;
        ready_mode = 3;
        base_addr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        base_m     = base_addr;
        fw_m       = 0;
        push_words(4);
        buf_cnt = 32'd4;
        last4x4 = 1'b1;
        tick(1);
        last4x4 = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick(1);
            if (acc_cnt == acc0 + 1 && wr_req) found = 1'b1;
        end
        check("rst_reached_word2", 32'(found), 32'd1);
        rst = 1'b1;
        tick(1);
        check_zero_outputs();
        rst = 1'b0;
        exp_q.delete();
        buf_cnt = '0;
        ready_mode = 1;
        tick(2);
        run_frame(2, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1, 0);
    endtask

    initial begin
        rst        = 1'b1;
        h264_reset = 1'b0;
        drain_en   = 1'b1;
        base_addr  = '0;
        last4x4    = 1'b0;
        buf_cnt    = '0;
        for (int i = 0; i < DEPTH; i++) buf_mem[i] = $urandom;
        tick(3);
        check_zero_outputs();
        rst = 1'b0;
        tick(2);

        run_frame(3, 32'h0000_1000, 1, 0);
        full_then_frame();
        run_frame(7, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 2, 0);
        run_frame(0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1, 0);
        run_frame(4, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 4, 10);
        reset_mid_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
